// File: rtl/tick_scheduler.sv
// tick_scheduler
//   Shared gameplay timing resource. One prescaler divides clk_in into a base
//   tick, and NUM_CH channels count base ticks to produce one-cycle clock-enable
//   pulses. Every output is a clock enable in the clk_in domain; no clock is derived.
//
//   Optional build macro: TICK_ONESHOT_EN adds the cfg_oneshot port and per-channel
//   one-shot mode. Without it, every channel is periodic.
//
// Ports
//   clk_in       in   system clock
//   rst_n        in   asynchronous active-low reset
//   run          in   global enable; low freezes the prescaler phase and the channels
//   cfg_valid    in   config write request
//   cfg_ready    out  config write accepted when cfg_valid && cfg_ready
//   cfg_ch       in   [CH_W]  channel to configure (>= NUM_CH is accepted and ignored)
//   cfg_period   in   [CNT_W] period in base ticks; 0 disables the channel
//   cfg_oneshot  in   one-shot select (TICK_ONESHOT_EN only)
//   base_tick    out  one-cycle pulse every PRESCALE running cycles
//   tick         out  [NUM_CH] per-channel one-cycle pulse, aligned with base_tick
//   busy         out  [NUM_CH] channel holds a nonzero period

// ---------------------------------------------------------------------------
// tick_channel: a single lane. IDLE means period==0. ACTIVE counts strobes and
// reloads from the period register each time the count reaches 1.
// ---------------------------------------------------------------------------
module tick_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             strobe,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_period,
  input  logic             wr_oneshot,
  output logic             tick,
  output logic             busy
);

  typedef enum logic {CH_IDLE, CH_ACTIVE} ch_st_e;

  ch_st_e           st, st_n;
  logic [CNT_W-1:0] period, period_n;
  logic [CNT_W-1:0] count, count_n;
  logic             oneshot, oneshot_n;
  logic             tick_n;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      st      <= CH_IDLE;
      period  <= '0;
      count   <= '0;
      oneshot <= 1'b0;
      tick    <= 1'b0;
    end else begin
      st      <= st_n;
      period  <= period_n;
      count   <= count_n;
      oneshot <= oneshot_n;
      tick    <= tick_n;
    end
  end

  always_comb begin
    st_n      = st;
    period_n  = period;
    count_n   = count;
    oneshot_n = oneshot;
    tick_n    = 1'b0;
    if (wr_en) begin
      // A write beats a coincident strobe: the count is reloaded and that strobe
      // is swallowed for this lane.
      period_n  = wr_period;
      count_n   = wr_period;
      oneshot_n = wr_oneshot;
      st_n      = (wr_period == '0) ? CH_IDLE : CH_ACTIVE;
    end else if (strobe && st == CH_ACTIVE) begin
      if (count == CNT_W'(1)) begin
        tick_n = 1'b1;
        if (oneshot) begin
          // The lane drops to IDLE on the same edge that raises tick, so busy
          // falls in the same cycle as the pulse.
          st_n     = CH_IDLE;
          period_n = '0;
          count_n  = '0;
        end else begin
          count_n = period;
        end
      end else begin
        count_n = count - CNT_W'(1);
      end
    end
  end

  // busy comes straight from the state register, so it is a registered output.
  assign busy = (st == CH_ACTIVE);

endmodule

// ---------------------------------------------------------------------------
// tick_scheduler: prescaler, config handshake, and the array of lanes
// ---------------------------------------------------------------------------
module tick_scheduler #(
  parameter int PRESCALE = 10000,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
`ifdef TICK_ONESHOT_EN
  input  logic              cfg_oneshot,
`endif
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] period;
    logic             oneshot;
  } cfg_req_t;

  cfg_req_t          req;
  logic              accept;
  logic [PW-1:0]     pre_cnt;
  logic              strobe;
  logic [NUM_CH-1:0] wr_en;

  always_comb begin
    req.ch     = cfg_ch;
    req.period = cfg_period;
`ifdef TICK_ONESHOT_EN
    req.oneshot = cfg_oneshot;
`else
    req.oneshot = 1'b0;
`endif
  end

  assign accept = cfg_valid && cfg_ready;

  // Ready is low out of reset, rises on the first edge after release, and takes
  // a one-cycle gap after each accepted write. That limits writes to one every
  // two cycles.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) cfg_ready <= 1'b0;
    else        cfg_ready <= !accept;
  end

  // Prescaler. While run is low the phase is held, so the next base tick arrives
  // only after the rest of the interrupted period has elapsed.
  assign strobe = run && (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= strobe;
      if (run) begin
        if (pre_cnt == PW'(PRESCALE - 1)) pre_cnt <= '0;
        else                              pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  // Lanes. A cfg_ch of NUM_CH or more matches no lane: the handshake completes
  // and no channel state changes.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_en[g] = accept && (req.ch == CH_W'(g));

    tick_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .strobe     (strobe),
      .wr_en      (wr_en[g]),
      .wr_period  (req.period),
      .wr_oneshot (req.oneshot),
      .tick       (tick[g]),
      .busy       (busy[g])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;
  localparam int PRE = 4;
  localparam int NCH = 4;
  localparam int CHW = 3;
  localparam int CW  = 16;

  logic           clk_in = 1'b0;
  logic           rst_n  = 1'b1;
  logic           run = 1'b0, cfg_valid = 1'b0, cfg_oneshot = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_period = '0;
  logic           cfg_ready, base_tick;
  logic [NCH-1:0] tick, busy;

  int n_chk = 0, n_err = 0;

  tick_scheduler #(.PRESCALE(PRE), .NUM_CH(NCH), .CH_W(CHW), .CNT_W(CW)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .run        (run),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
`ifdef TICK_ONESHOT_EN
    .cfg_oneshot(cfg_oneshot),
`endif
    .base_tick  (base_tick),
    .tick       (tick),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. It tracks the absolute strobe index at which each channel
  // fires next. At every edge it pushes the expected outputs for that edge.
  typedef struct packed {
    logic           base;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] bs;
    logic           rdy;
  } exp_t;

  exp_t sb[$];
  int   ph = 0, bt = 0;
  bit   m_rdy = 0;
  int   m_per[NCH];
  int   nxt[NCH];
  bit   m_os[NCH];

  always @(posedge clk_in or negedge rst_n) begin
    exp_t e;
    bit   stb, acc;
    if (!rst_n) begin
      ph = 0; bt = 0; m_rdy = 0;
      for (int c = 0; c < NCH; c++) begin m_per[c] = 0; nxt[c] = 0; m_os[c] = 0; end
      sb.delete();
    end else begin
      stb = run && (ph == PRE - 1);
      if (run) ph = (ph + 1) % PRE;
      if (stb) bt++;
      acc = cfg_valid && m_rdy;
      e = '0;
      e.base = stb;
      for (int c = 0; c < NCH; c++) begin
        if (acc && int'(cfg_ch) == c) begin
          m_per[c] = int'(cfg_period);
          nxt[c]   = bt + int'(cfg_period);
          m_os[c]  = cfg_oneshot;
        end else if (stb && m_per[c] != 0 && nxt[c] == bt) begin
          e.tk[c] = 1'b1;
          if (m_os[c]) m_per[c] = 0;
          else         nxt[c] += m_per[c];
        end
        e.bs[c] = (m_per[c] != 0);
      end
      m_rdy = !acc;
      e.rdy = m_rdy;
      sb.push_back(e);
    end
  end

  always @(negedge clk_in) begin
    exp_t e;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_base_tick", 32'(base_tick), 32'(e.base));
      chk("sb_tick",      32'(tick),      32'(e.tk));
      chk("sb_busy",      32'(busy),      32'(e.bs));
      chk("sb_cfg_ready", 32'(cfg_ready), 32'(e.rdy));
    end
  end

  // Must be called right after a negedge.
  task automatic wr(input int ch, input int per, input bit os);
    int w = 0;
    while (!m_rdy && w < 10) begin @(negedge clk_in); w++; end
    if (w >= 10) chk("wr_ready_timeout", 0, 1);
    cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_period = CW'(per); cfg_oneshot = os;
    @(negedge clk_in);
    cfg_valid = 1'b0; cfg_oneshot = 1'b0;
    chk("ready_drop", 32'(cfg_ready), 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    int k, c, w;
    bit found;
    // 1: reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_base_tick", 32'(base_tick), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cfg_ready), 0);
    cyc(3);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(cfg_ready), 0);
    @(negedge clk_in);
    chk("ready_after_edge", 32'(cfg_ready), 1);

    // 2: prescaler, then pause and resume
    run = 1'b1;
    cyc(17);
    w = 0;
    while (ph != 2 && w < 10) begin @(negedge clk_in); w++; end
    run = 1'b0;
    cyc(10);
    k = ph;
    chk("pause_phase_held", k, 2);
    run = 1'b1;
    c = 0;
    found = 0;
    while (!found && c < 10) begin @(negedge clk_in); c++; found = base_tick; end
    chk("resume_latency", c, PRE - k);

    // 3: ch0 period 3
    wr(0, 3, 0);
    w = 0;
    while (!tick[0] && w < 40) begin @(negedge clk_in); w++; end
    chk("tick0_with_base", 32'(base_tick), 1);
    c = 0;
    found = 0;
    while (!found && c < 40) begin @(negedge clk_in); c++; found = tick[0]; end
    chk("tick0_interval", c, 3 * PRE);

    // 4: ch1 period 2, rewritten in the strobe cycle where its count is 1
    wr(1, 2, 0);
    w = 0;
    found = 0;
    while (!found && w < 100) begin
      @(negedge clk_in); w++;
      found = run && ph == PRE - 1 && m_per[1] != 0 && nxt[1] == bt + 1 && m_rdy;
    end
    chk("align_found", 32'(found), 1);
    wr(1, 2, 0);
    chk("rewrite_strobe", 32'(base_tick), 1);
    chk("rewrite_no_tick", 32'(tick[1]), 0);
    cyc(40);

    // 5: ch2 disable and out-of-range channel
    wr(2, 1, 0);
    cyc(12);
    wr(2, 0, 0);
    chk("ch2_idle", 32'(busy[2]), 0);
    cyc(30);
    wr(5, 7, 0);
    cyc(20);

`ifdef TICK_ONESHOT_EN
    // 6: one-shot
    wr(3, 2, 1);
    w = 0;
    while (!tick[3] && w < 40) begin @(negedge clk_in); w++; end
    chk("os_tick_seen", 32'(tick[3]), 1);
    chk("os_busy_falls", 32'(busy[3]), 0);
    c = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk_in); if (tick[3]) c++; end
    chk("os_no_more", c, 0);
`endif

    // Mid-count reset, after the scoreboard has popped this cycle's entry
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tick", 32'(tick), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_base", 32'(base_tick), 0);
    chk("mid_rst_ready", 32'(cfg_ready), 0);
    cyc(3);
    chk("mid_rst_hold_tick", 32'(tick), 0);
    rst_n = 1'b1;
    cyc(30);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
